// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command/ALU/result bundle between sequencer and its environment
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_FUN;
  logic             Enable;
  logic [WIDTH-1:0] ALU_OUT;
  logic             OUT_VALID;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             timeout_err;

  // Sequencer side
  modport master (
    input  rx_data, rx_valid, ALU_OUT, OUT_VALID, tx_ready,
    output rx_ready, A, B, ALU_FUN, Enable, tx_data, tx_valid, busy, timeout_err
  );

  // Environment side: command source, ALU and result sink
  modport slave (
    output rx_data, rx_valid, ALU_OUT, OUT_VALID, tx_ready,
    input  rx_ready, A, B, ALU_FUN, Enable, tx_data, tx_valid, busy, timeout_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - byte-serial command framer, ALU issue/capture and LSB-first result return
module alu_cmd_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input logic                 clk,
  input logic                 RST,
  alu_cmd_sequencer_if.master bus
);
  localparam int NB = WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(NB - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, GET_A, GET_B, ISSUE, WAIT, SEND} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_shift;
  logic             rx_fire;
  logic             tx_fire;

  assign rx_fire      = bus.rx_valid && bus.rx_ready;
  assign tx_fire      = bus.tx_valid && bus.tx_ready;
  // The result register shifts down one byte per accepted tx byte, so byte 0 is always next
  assign result_shift = result >> 8;

  // Frame FSM; every output is a register so nothing glitches toward the ALU or the stream sinks
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state           <= IDLE;
      cnt             <= '0;
      timer           <= '0;
      result          <= '0;
      bus.rx_ready    <= 1'b0;
      bus.A           <= '0;
      bus.B           <= '0;
      bus.ALU_FUN     <= '0;
      bus.Enable      <= 1'b0;
      bus.tx_data     <= '0;
      bus.tx_valid    <= 1'b0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.Enable      <= 1'b0;
      bus.timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          bus.rx_ready <= 1'b1;
          if (rx_fire) begin
            bus.ALU_FUN <= bus.rx_data[3:0];
            cnt         <= '0;
            bus.busy    <= 1'b1;
            state       <= GET_A;
          end
        end
        GET_A: begin
          if (rx_fire) begin
            for (int i = 0; i < NB; i++) begin
              if (cnt == CW'(i)) bus.A[8*i +: 8] <= bus.rx_data;
            end
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= GET_B;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        GET_B: begin
          if (rx_fire) begin
            for (int i = 0; i < NB; i++) begin
              if (cnt == CW'(i)) bus.B[8*i +: 8] <= bus.rx_data;
            end
            if (cnt == CNT_LAST) begin
              // Close the input before ISSUE so no byte of a following frame can slip in
              bus.rx_ready <= 1'b0;
              bus.Enable   <= 1'b1;
              state        <= ISSUE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (bus.OUT_VALID) begin
            result       <= bus.ALU_OUT;
            bus.tx_data  <= bus.ALU_OUT[7:0];
            bus.tx_valid <= 1'b1;
            cnt          <= '0;
            state        <= SEND;
          end else if (timer == TIMER_LAST) begin
            bus.timeout_err <= 1'b1;
            bus.busy        <= 1'b0;
            bus.rx_ready    <= 1'b1;
            state           <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SEND: begin
          if (tx_fire) begin
            if (cnt == CNT_LAST) begin
              bus.tx_valid <= 1'b0;
              bus.busy     <= 1'b0;
              bus.rx_ready <= 1'b1;
              state        <= IDLE;
            end else begin
              cnt         <= cnt + 1'b1;
              result      <= result_shift;
              bus.tx_data <= result_shift[7:0];
            end
          end
        end
        default: begin
          bus.busy     <= 1'b0;
          bus.tx_valid <= 1'b0;
          bus.rx_ready <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - directed table-driven bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 15;

  logic clk;
  logic RST;
  int   total;
  int   bad;
  int   en_cnt;
  int   to_cnt;

  alu_cmd_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_cmd_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [7:0]  f;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] alu;
    int          stall;
    int          gap;      // -1 selects a random 0..3 cycle gap before each byte
    logic [3:0]  exp_fun;
    logic [7:0]  exp_tx0;
    logic [7:0]  exp_tx1;
  } vec_t;

  vec_t vt[4];
  vec_t vr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (bus.Enable)      en_cnt <= en_cnt + 1;
    if (bus.timeout_err) to_cnt <= to_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    int guard;
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.rx_data  = d;
    bus.rx_valid = 1'b1;
    guard = 0;
    while (!bus.rx_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("rx_ready_wait", {31'd0, bus.rx_ready}, 32'd1);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    logic [7:0] fr[5];
    fr[0] = v.f;
    fr[1] = v.a[7:0];
    fr[2] = v.a[15:8];
    fr[3] = v.b[7:0];
    fr[4] = v.b[15:8];
    for (int i = 0; i < 5; i++)
      send_byte(fr[i], (v.gap < 0) ? int'($urandom_range(0, 3)) : v.gap);
  endtask

  task automatic run_frame(input vec_t v);
    int         e0;
    int         got;
    int         guard;
    logic [7:0] rb[2];
    e0 = en_cnt;
    send_frame(v);
    // Last B byte accepted at the previous edge: this is the ISSUE cycle
    chk("enable_issue", {31'd0, bus.Enable}, 32'd1);
    chk("fun", {28'd0, bus.ALU_FUN}, {28'd0, v.exp_fun});
    chk("a", {16'd0, bus.A}, {16'd0, v.a});
    chk("b", {16'd0, bus.B}, {16'd0, v.b});
    chk("rx_ready_issue", {31'd0, bus.rx_ready}, 32'd0);
    @(negedge clk);
    chk("enable_wait", {31'd0, bus.Enable}, 32'd0);
    bus.OUT_VALID = 1'b1;
    bus.ALU_OUT   = v.alu;
    @(negedge clk);
    bus.OUT_VALID = 1'b0;
    bus.ALU_OUT   = 16'hBEEF;
    chk("tx_valid_latency", {31'd0, bus.tx_valid}, 32'd1);
    bus.tx_ready = 1'b0;
    for (int s = 0; s < v.stall; s++) begin
      chk("stall_valid", {31'd0, bus.tx_valid}, 32'd1);
      chk("stall_data", {24'd0, bus.tx_data}, {24'd0, v.exp_tx0});
      @(negedge clk);
    end
    bus.tx_ready = 1'b1;
    got = 0;
    guard = 0;
    while (got < 2 && guard < 20) begin
      if (bus.tx_valid) begin
        rb[got] = bus.tx_data;
        got++;
      end
      @(negedge clk);
      guard++;
    end
    bus.tx_ready = 1'b0;
    chk("tx_count", got, 2);
    if (got == 2) begin
      chk("tx0", {24'd0, rb[0]}, {24'd0, v.exp_tx0});
      chk("tx1", {24'd0, rb[1]}, {24'd0, v.exp_tx1});
    end
    chk("tx_valid_drop", {31'd0, bus.tx_valid}, 32'd0);
    chk("busy_done", {31'd0, bus.busy}, 32'd0);
    chk("rx_ready_done", {31'd0, bus.rx_ready}, 32'd1);
    chk("fun_hold", {28'd0, bus.ALU_FUN}, {28'd0, v.exp_fun});
    chk("enable_once", en_cnt - e0, 1);
  endtask

  initial begin
    vt[0] = '{8'h00, 16'h000A, 16'h0005, 16'h000F, 0, 0, 4'h0, 8'h0F, 8'h00};
    vt[1] = '{8'hF7, 16'h000A, 16'h0005, 16'hFFF0, 0, 1, 4'h7, 8'hF0, 8'hFF};
    vt[2] = '{8'h03, 16'h1234, 16'hABCD, 16'h5678, 5, 0, 4'h3, 8'h78, 8'h56};
    vt[3] = '{8'h0C, 16'hFFFF, 16'h0001, 16'h8001, 2, -1, 4'hC, 8'h01, 8'h80};
    vr    = '{8'h05, 16'h0102, 16'h0304, 16'h0A0B, 0, 0, 4'h5, 8'h0B, 8'h0A};

    total = 0;
    bad = 0;
    en_cnt = 0;
    to_cnt = 0;
    RST = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    bus.ALU_OUT = '0;
    bus.OUT_VALID = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    chk("rst_a", {16'd0, bus.A}, 32'd0);
    chk("rst_b", {16'd0, bus.B}, 32'd0);
    chk("rst_fun", {28'd0, bus.ALU_FUN}, 32'd0);
    chk("rst_enable", {31'd0, bus.Enable}, 32'd0);
    chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_timeout", {31'd0, bus.timeout_err}, 32'd0);
    RST = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", {31'd0, bus.rx_ready}, 32'd1);

    // Table-driven frames
    for (int i = 0; i < 4; i++) run_frame(vt[i]);

    // ALU never answers: timeout pulse exactly TIMEOUT cycles after WAIT entry
    begin
      int   t0;
      int   hit;
      logic txseen;
      vec_t vto;
      vto = '{8'h01, 16'h0003, 16'h0004, 16'h0000, 0, 0, 4'h1, 8'h00, 8'h00};
      send_frame(vto);
      chk("to_enable", {31'd0, bus.Enable}, 32'd1);
      t0 = to_cnt;
      hit = -1;
      txseen = 1'b0;
      for (int k = 1; k <= TIMEOUT + 4; k++) begin
        @(negedge clk);
        if (bus.timeout_err && hit < 0) hit = k;
        if (bus.tx_valid) txseen = 1'b1;
      end
      chk("to_latency", hit, TIMEOUT + 1);
      chk("to_once", to_cnt - t0, 1);
      chk("to_no_tx", {31'd0, txseen}, 32'd0);
      chk("to_busy", {31'd0, bus.busy}, 32'd0);
      // Late OUT_VALID after the abort must be ignored
      bus.OUT_VALID = 1'b1;
      bus.ALU_OUT = 16'h1111;
      @(negedge clk);
      bus.OUT_VALID = 1'b0;
      @(negedge clk);
      chk("late_ov_tx", {31'd0, bus.tx_valid}, 32'd0);
      chk("late_ov_busy", {31'd0, bus.busy}, 32'd0);
    end
    run_frame(vt[0]);

    // Reset after 3 bytes of a frame, then a fresh frame
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_a", {16'd0, bus.A}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    chk("mid_rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    @(negedge clk);
    RST = 1'b0;
    run_frame(vr);

    // Stray OUT_VALID in IDLE, then a frame with random rx gaps
    bus.OUT_VALID = 1'b1;
    bus.ALU_OUT = 16'hDEAD;
    @(negedge clk);
    bus.OUT_VALID = 1'b0;
    @(negedge clk);
    chk("stray_tx", {31'd0, bus.tx_valid}, 32'd0);
    chk("stray_busy", {31'd0, bus.busy}, 32'd0);
    run_frame(vt[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
